pc_unit: RTL

- Parametrised program-counter unit for the pipelined MIPS core.
- Merges the PC register and the PC+4 incrementer into one block.
- Adds stall hold, branch/jump redirect, exception vectoring, and a one-entry buffer that holds a redirect arriving during a stall.
- Sits at the head of IF; drives the instruction-memory address and the IF/ID PC+4 field.

---
 rtl/pc_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit at the head of the IF stage.
//
// Holds the fetch PC and produces PC+INC. Supports stall hold, branch/jump
// redirect (branch beats jump), exception vectoring and a one-entry buffer
// that keeps a redirect which arrives while the pipeline is stalled.
//
// Optional build macro: PC_ALIGN_CHK_EN
//   When defined, a redirect whose target has bits[1:0] != 0 is replaced by
//   EXC_VECTOR and the extra output `misalign` pulses alongside `flush`.
//   When undefined, targets are loaded verbatim and `misalign` does not exist.
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous reset, active low
//   stall             hold PC this cycle
//   br_taken          branch resolved taken
//   br_target         branch target
//   jmp_valid         jump request
//   jmp_target        jump target
//   exc_req           exception request (overrides stall and any redirect)
//   pc                current fetch address (registered)
//   pc_next_seq       pc + INC (combinational, wraps)
//   flush             registered pulse: pc now holds a redirected value
//   redirect_pending  registered: a redirect is buffered
//   misalign          (PC_ALIGN_CHK_EN only) registered pulse: a misaligned
//                     redirect was replaced by EXC_VECTOR
//
// State | meaning
// ------+------------------------------------------------------------
// RUN   | normal fetch; no redirect buffered
// PEND  | a redirect arrived during a stall; applied when stall drops

module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(32'h0000_0080),
  parameter int              INC          = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            jmp_valid,
  input  logic [XLEN-1:0] jmp_target,
  input  logic            exc_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            flush,
  output logic            redirect_pending
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic            misalign
`endif
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  state_t          state;
  logic [XLEN-1:0] pend_target;

  logic            redir;
  logic [XLEN-1:0] redir_target;
  // Values actually loaded into pc for an immediate or buffered redirect,
  // after any alignment substitution.
  logic [XLEN-1:0] run_load;
  logic [XLEN-1:0] pend_load;

  assign pc_next_seq  = pc + XLEN'(INC);
  assign redir        = br_taken | jmp_valid;
  assign redir_target = br_taken ? br_target : jmp_target;

`ifdef PC_ALIGN_CHK_EN
  logic run_bad;
  logic pend_bad;

  // The buffer keeps the raw target; the check happens when it is applied.
  always_comb begin
    run_bad   = (redir_target[1:0] != 2'b00);
    pend_bad  = (pend_target[1:0] != 2'b00);
    run_load  = run_bad  ? EXC_VECTOR : redir_target;
    pend_load = pend_bad ? EXC_VECTOR : pend_target;
  end
`else
  assign run_load  = redir_target;
  assign pend_load = pend_target;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RUN;
      pc               <= RESET_VECTOR;
      pend_target      <= '0;
      flush            <= 1'b0;
      redirect_pending <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      misalign         <= 1'b0;
`endif
    end else begin
      flush <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      misalign <= 1'b0;
`endif
      case (state)
        RUN: begin
          if (exc_req) begin
            pc    <= EXC_VECTOR;
            flush <= 1'b1;
          end else if (redir && !stall) begin
            pc    <= run_load;
            flush <= 1'b1;
`ifdef PC_ALIGN_CHK_EN
            misalign <= run_bad;
`endif
          end else if (redir) begin
            pend_target      <= redir_target;
            redirect_pending <= 1'b1;
            state            <= PEND;
          end else if (!stall) begin
            pc <= pc_next_seq;
          end
        end
        PEND: begin
          // New redirects are ignored here: the oldest one wins.
          if (exc_req) begin
            pc               <= EXC_VECTOR;
            flush            <= 1'b1;
            redirect_pending <= 1'b0;
            state            <= RUN;
          end else if (!stall) begin
            pc               <= pend_load;
            flush            <= 1'b1;
            redirect_pending <= 1'b0;
            state            <= RUN;
`ifdef PC_ALIGN_CHK_EN
            misalign <= pend_bad;
`endif
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
